clock_divider_multi: RTL and testbench

Multi-channel, runtime-programmable clock divider. It generates `N_CH` independent divided clocks from `clk_in`, and each channel has its own one-cycle tick strobe. Divisors are written through a shadow register and take effect only at period boundaries, so output changes never glitch. Channels can also be phase-aligned with a global sync. The block replaces fixed-ratio dividers wherever several slow enables or display/scan clocks are derived from the board clock.

---
 rtl/clock_divider_pkg.sv | 24 ++
 rtl/clock_divider_ch.sv | 95 +++++++++
 rtl/clock_divider_multi.sv | 51 +++++
 tb/tb_clock_divider_multi.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Helpers work on 32-bit values; callers cast to their own counter width.
package clock_divider_pkg;

   localparam int MAX_W = 32;

   typedef enum logic {IDLE, RUN} ch_state_t;

   function automatic logic [MAX_W-1:0] clamp_div(input logic [MAX_W-1:0] x);
      return (x < MAX_W'(2)) ? MAX_W'(2) : x;
   endfunction

   // One extra bit so the +1 cannot wrap at the largest divisor.
   function automatic logic [MAX_W:0] high_len(input logic [MAX_W-1:0] d);
      return ({1'b0, d} + (MAX_W+1)'(1)) >> 1;
   endfunction

   function automatic int default_div(input int fIn, input int fOut);
      int q;
      q = fIn / fOut;
      return (q < 2) ? 2 : q;
   endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: run/idle state, phase counter, active and shadow
// divisors, and registered clock/tick/busy outputs.
module clock_divider_ch
   import clock_divider_pkg::*;
#(
   parameter int               CNT_W       = 16,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(10)
)(
   input  logic             clk_in,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wrEn,
   input  logic [CNT_W-1:0] i_wrDiv,
   output logic             o_clkOut,
   output logic             o_tick,
   output logic             o_busy
);

   ch_state_t        r_state;
   ch_state_t        w_stateNext;
   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] w_phaseNext;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] w_divNext;
   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] w_wrDivClamped;
   logic [CNT_W:0]   w_highLen;
   logic             w_lastPhase;
   logic             w_clkOutNext;
   logic             w_tickNext;
   logic             w_busyNext;

   assign w_wrDivClamped = CNT_W'(clamp_div(MAX_W'(i_wrDiv)));
   assign w_lastPhase    = (r_phase == r_div - CNT_W'(1));

   // Sync beats the normal period advance; a running period is never cut short by en.
   always_comb begin
      w_stateNext = r_state;
      w_phaseNext = r_phase;
      w_divNext   = r_div;
      if (i_sync && (r_state == RUN || i_en)) begin
         w_stateNext = RUN;
         w_phaseNext = '0;
         w_divNext   = r_shadow;
      end else if (r_state == IDLE) begin
         if (i_en) begin
            w_stateNext = RUN;
            w_phaseNext = '0;
            w_divNext   = r_shadow;
         end
      end else if (w_lastPhase) begin
         w_phaseNext = '0;
         if (i_en) begin
            w_divNext = r_shadow;
         end else begin
            w_stateNext = IDLE;
         end
      end else begin
         w_phaseNext = r_phase + CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      w_highLen    = (CNT_W+1)'(high_len(MAX_W'(w_divNext)));
      w_busyNext   = (w_stateNext == RUN);
      w_clkOutNext = w_busyNext && ({1'b0, w_phaseNext} < w_highLen);
      w_tickNext   = w_busyNext && (w_phaseNext == '0);
   end

   // Reset discards any pending load and restores the default divisor.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state  <= IDLE;
         r_phase  <= '0;
         r_div    <= DEFAULT_DIV;
         r_shadow <= DEFAULT_DIV;
         o_clkOut <= 1'b0;
         o_tick   <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_phase  <= w_phaseNext;
         r_div    <= w_divNext;
         if (i_wrEn) begin
            r_shadow <= w_wrDivClamped;
         end
         o_clkOut <= w_clkOutNext;
         o_tick   <= w_tickNext;
         o_busy   <= w_busyNext;
      end
   end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes to one
// channel and replicates the per-channel divider.
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int CNT_W = 16,
   parameter  int F_IN  = 100,
   parameter  int F_OUT = 10,
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic              clk_in,
   input  logic              reset,
   input  logic [N_CH-1:0]   en,
   input  logic              sync,
   input  logic              load,
   input  logic [SEL_W-1:0]  load_ch,
   input  logic [CNT_W-1:0]  load_div,
   output logic [N_CH-1:0]   clk_out,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   busy
);

   localparam logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(default_div(F_IN, F_OUT));

   logic            w_selValid;
   logic [N_CH-1:0] w_wrEn;

   // Selector codes past the last channel are dropped rather than aliased.
   assign w_selValid = (32'(load_ch) < 32'(N_CH));

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign w_wrEn[i] = load && w_selValid && (load_ch == SEL_W'(i));

      clock_divider_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in   (clk_in),
         .reset    (reset),
         .i_en     (en[i]),
         .i_sync   (sync),
         .i_wrEn   (w_wrEn[i]),
         .i_wrDiv  (load_div),
         .o_clkOut (clk_out[i]),
         .o_tick   (tick[i]),
         .o_busy   (busy[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomized and directed bench for clock_divider_multi, checked every cycle
// against an integer-level model of the channel rules.
module tb_clock_divider_multi;

   localparam int N_CH    = 5;
   localparam int CNT_W   = 5;
   localparam int SEL_W   = 3;
   localparam int DEF_DIV = 10;

   logic             clk_in   = 1'b0;
   logic             reset    = 1'b1;
   logic [N_CH-1:0]  en       = '0;
   logic             sync     = 1'b0;
   logic             load     = 1'b0;
   logic [SEL_W-1:0] load_ch  = '0;
   logic [CNT_W-1:0] load_div = '0;
   logic [N_CH-1:0]  clk_out;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   clock_divider_multi #(
      .N_CH  (N_CH),
      .CNT_W (CNT_W),
      .F_IN  (100),
      .F_OUT (10)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .en       (en),
      .sync     (sync),
      .load     (load),
      .load_ch  (load_ch),
      .load_div (load_div),
      .clk_out  (clk_out),
      .tick     (tick),
      .busy     (busy)
   );

   // Reference model: per channel a running flag, phase, active and shadow divisor.
   bit mRun[N_CH];
   int mP[N_CH];
   int mD[N_CH];
   int mS[N_CH];
   bit modelValid = 1'b0;

   initial begin
      forever begin
         @(posedge clk_in);
         if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
               mRun[i] = 1'b0;
               mP[i]   = 0;
               mD[i]   = DEF_DIV;
               mS[i]   = DEF_DIV;
            end
            modelValid = 1'b1;
         end else if (modelValid) begin
            for (int i = 0; i < N_CH; i++) begin
               int newS;
               newS = mS[i];
               if (load && int'(load_ch) == i)
                  newS = (int'(load_div) < 2) ? 2 : int'(load_div);
               if (sync && (mRun[i] || en[i])) begin
                  mRun[i] = 1'b1;
                  mP[i]   = 0;
                  mD[i]   = mS[i];
               end else if (!mRun[i]) begin
                  if (en[i]) begin
                     mRun[i] = 1'b1;
                     mP[i]   = 0;
                     mD[i]   = mS[i];
                  end
               end else if (mP[i] == mD[i] - 1) begin
                  mP[i] = 0;
                  if (en[i]) mD[i] = mS[i];
                  else       mRun[i] = 1'b0;
               end else begin
                  mP[i] = mP[i] + 1;
               end
               mS[i] = newS;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_in);
         if (modelValid) begin
            logic [N_CH-1:0] eClk, eTick, eBusy;
            for (int i = 0; i < N_CH; i++) begin
               eBusy[i] = mRun[i];
               eClk[i]  = mRun[i] && (mP[i] < (mD[i] + 1) / 2);
               eTick[i] = mRun[i] && (mP[i] == 0);
            end
            checkOutput("model_clk_out", 32'(clk_out), 32'(eClk));
            checkOutput("model_tick",    32'(tick),    32'(eTick));
            checkOutput("model_busy",    32'(busy),    32'(eBusy));
         end
      end
   end

   // Drives one cycle of inputs at a falling edge and returns at the next one.
   task automatic applyStimulus(input logic rst, input logic [N_CH-1:0] e, input logic s,
                                input logic ld, input logic [SEL_W-1:0] ch,
                                input logic [CNT_W-1:0] dv);
      reset    = rst;
      en       = e;
      sync     = s;
      load     = ld;
      load_ch  = ch;
      load_div = dv;
      @(negedge clk_in);
   endtask

   initial begin
      logic [31:0]     vA, vB, vC;
      logic [N_CH-1:0] e;

      @(negedge clk_in);
      applyStimulus(1, '0, 0, 0, 0, 0);
      applyStimulus(1, '0, 0, 0, 0, 0);
      checkOutput("reset_clk_out", 32'(clk_out), 32'h0);
      checkOutput("reset_tick",    32'(tick),    32'h0);
      checkOutput("reset_busy",    32'(busy),    32'h0);

      // Default divisor 10 on channel 0.
      vA = '0; vB = '0; vC = '0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(0, 5'b00001, 0, 0, 0, 0);
         vA = {vA[30:0], clk_out[0]};
         vB = {vB[30:0], tick[0]};
         vC = {vC[30:0], busy[0]};
      end
      checkOutput("default_clk0",  vA, 32'b11111000001111100000);
      checkOutput("default_tick0", vB, 32'b10000000001000000000);
      checkOutput("default_busy0", vC, 32'hFFFFF);

      // Channel 1 reloaded to 7 mid-period: current 10-cycle period finishes first.
      vA = '0;
      for (int k = 0; k < 24; k++) begin
         applyStimulus(0, 5'b00011, 0, (k == 1), 3'd1, 5'd7);
         vA = {vA[30:0], clk_out[1]};
      end
      checkOutput("reload_clk1", vA, 32'b111110000011110001111000);

      // Divisors 0 and 1 clamp to 2; out-of-range selectors change nothing.
      applyStimulus(0, 5'b00011, 0, 1, 3'd3, 5'd0);
      applyStimulus(0, 5'b00011, 0, 1, 3'd4, 5'd1);
      vA = '0; vB = '0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 5'b11011, 0, 0, 0, 0);
         vA = {vA[30:0], clk_out[3]};
         vB = {vB[30:0], clk_out[4]};
      end
      checkOutput("clamp0_clk3", vA, 32'b101010);
      checkOutput("clamp1_clk4", vB, 32'b101010);
      applyStimulus(0, 5'b11011, 0, 1, 3'd5, 5'd3);
      applyStimulus(0, 5'b11011, 0, 1, 3'd7, 5'd3);

      // Channel 2 disabled at phase 1: the period still completes.
      vA = '0; vB = '0; vC = '0;
      for (int k = 0; k < 14; k++) begin
         e = (k < 2) ? 5'b11111 : 5'b11011;
         applyStimulus(0, e, 0, 0, 0, 0);
         vA = {vA[30:0], clk_out[2]};
         vB = {vB[30:0], busy[2]};
         vC = {vC[30:0], tick[2]};
      end
      checkOutput("drop_en_clk2",  vA, 32'b11111000000000);
      checkOutput("drop_en_busy2", vB, 32'b11111111110000);
      checkOutput("drop_en_tick2", vC, 32'b10000000000000);

      // Sync realigns channels running at 6 and 9.
      e = 5'b11011;
      applyStimulus(0, e, 0, 1, 3'd0, 5'd6);
      applyStimulus(0, e, 0, 1, 3'd1, 5'd9);
      for (int k = 0; k < 20; k++) applyStimulus(0, e, 0, 0, 0, 0);
      vA = '0; vB = '0; vC = '0;
      for (int k = 0; k < 18; k++) begin
         applyStimulus(0, e, (k == 0), 0, 0, 0);
         vA = {vA[30:0], tick[0]};
         vB = {vB[30:0], tick[1]};
         vC = {vC[30:0], clk_out[1]};
      end
      checkOutput("sync_tick0", vA, 32'b100000100000100000);
      checkOutput("sync_tick1", vB, 32'b100000000100000000);
      checkOutput("sync_clk1",  vC, 32'b111110000111110000);

      // Reset in the high phase with a simultaneous load and sync.
      applyStimulus(0, e, 0, 0, 0, 0);
      applyStimulus(0, e, 0, 0, 0, 0);
      checkOutput("pre_reset_clk0", 32'(clk_out[0]), 32'h1);
      applyStimulus(1, e, 1, 1, 3'd0, 5'd3);
      checkOutput("mid_reset_clk_out", 32'(clk_out), 32'h0);
      checkOutput("mid_reset_tick",    32'(tick),    32'h0);
      checkOutput("mid_reset_busy",    32'(busy),    32'h0);
      vA = '0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 5'b00001, 0, 0, 0, 0);
         vA = {vA[30:0], clk_out[0]};
      end
      checkOutput("post_reset_clk0", vA, 32'b1111100000);

      // Random traffic, checked by the model every cycle.
      e = 5'b00001;
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N_CH; i++)
            if ($urandom_range(0, 39) == 0) e[i] = ~e[i];
         applyStimulus(($urandom_range(0, 199) == 0), e, ($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 3) == 0), SEL_W'($urandom_range(0, 7)),
                       CNT_W'($urandom_range(0, 31)));
      end
      applyStimulus(0, e, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
